// File: rtl/reg_file_mp_pkg.sv
// Shared constants and types for the multi-read-port register file.
// Optional busy scoreboard is enabled by defining REGFILE_SCOREBOARD_EN.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NREAD_DEFAULT = 2;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] word_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between decode/writeback and the register file.
// The Issue/Issue_rd/Busy signals exist only when REGFILE_SCOREBOARD_EN is defined.
interface reg_file_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = NREAD_DEFAULT
);
    localparam int AW = $clog2(NREGS);

    logic              Wreg;
    logic [AW-1:0]     Wrd;
    logic [XLEN-1:0]   Wdata;
    logic [NREAD-1:0]  Ren;
    logic [AW-1:0]     Raddr [NREAD];
    logic [XLEN-1:0]   Rdata [NREAD];
`ifdef REGFILE_SCOREBOARD_EN
    logic              Issue;
    logic [AW-1:0]     Issue_rd;
    logic [NREAD-1:0]  Busy;

    modport master (output Wreg, Wrd, Wdata, Ren, Raddr, Issue, Issue_rd,
                    input  Rdata, Busy);
    modport slave  (input  Wreg, Wrd, Wdata, Ren, Raddr, Issue, Issue_rd,
                    output Rdata, Busy);
`else
    modport master (output Wreg, Wrd, Wdata, Ren, Raddr,
                    input  Rdata);
    modport slave  (input  Wreg, Wrd, Wdata, Ren, Raddr,
                    output Rdata);
`endif

endinterface

// File: rtl/reg_file_mp_rport.sv
// One read port: zero-register / write-bypass selection feeding an
// enable-gated output flop, plus the busy flop when REGFILE_SCOREBOARD_EN is defined.
module reg_file_rport
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     Ren,
    input  logic [$clog2(NREGS)-1:0] Raddr,
    input  logic                     Wreg,
    input  logic [$clog2(NREGS)-1:0] Wrd,
    input  logic [XLEN-1:0]          Wdata,
    input  logic [XLEN-1:0]          stored,
`ifdef REGFILE_SCOREBOARD_EN
    input  logic                     busy_in,
    output logic                     Busy,
`endif
    output logic [XLEN-1:0]          Rdata
);

    logic [XLEN-1:0] value;

    // Hardwired zero wins over the bypass; otherwise a same-cycle write is forwarded.
    always_comb begin
        value = stored;
        if (ZERO_REG != 0 && Raddr == '0)
            value = '0;
        else if (Wreg && Wrd == Raddr)
            value = Wdata;
    end

    // Registered read data; a low Ren holds the previous value for stalls.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            Rdata <= '0;
        else if (Ren)
            Rdata <= value;
    end

`ifdef REGFILE_SCOREBOARD_EN
    // Busy flag follows the post-update scoreboard state, held like Rdata.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            Busy <= 1'b0;
        else if (Ren)
            Busy <= busy_in;
    end
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with registered reads and write-first bypass.
// Define REGFILE_SCOREBOARD_EN to add the per-register busy scoreboard.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NREAD    = NREAD_DEFAULT,
    parameter int ZERO_REG = 1
) (
    input logic          Clock,
    input logic          nReset,
    reg_file_mp_if.slave bus
);

    logic [XLEN-1:0] regs [NREGS];

    // Storage array; writes to register 0 are dropped when it is hardwired to zero.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (bus.Wreg && !(ZERO_REG != 0 && bus.Wrd == '0)) begin
            regs[bus.Wrd] <= bus.Wdata;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;

    // Writeback clears a bit, issue sets one; set is applied last so it wins.
    always_comb begin
        busy_next = busy;
        if (bus.Wreg)
            busy_next[bus.Wrd] = 1'b0;
        if (bus.Issue && !(ZERO_REG != 0 && bus.Issue_rd == '0))
            busy_next[bus.Issue_rd] = 1'b1;
    end

    // Busy vector register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)
            busy <= '0;
        else
            busy <= busy_next;
    end
`endif

    for (genvar p = 0; p < NREAD; p++) begin : g_rport
        reg_file_rport #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG)
        ) u_rport (
            .Clock   (Clock),
            .nReset  (nReset),
            .Ren     (bus.Ren[p]),
            .Raddr   (bus.Raddr[p]),
            .Wreg    (bus.Wreg),
            .Wrd     (bus.Wrd),
            .Wdata   (bus.Wdata),
            .stored  (regs[bus.Raddr[p]]),
`ifdef REGFILE_SCOREBOARD_EN
            .busy_in (busy_next[bus.Raddr[p]]),
            .Busy    (bus.Busy[p]),
`endif
            .Rdata   (bus.Rdata[p])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard testbench for reg_file_mp (ZERO_REG=1, 2 read ports).
// Busy checks are compiled in when REGFILE_SCOREBOARD_EN is defined.
module tb_reg_file_mp;
    import regfile_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = $clog2(NREGS);

    typedef struct packed {
        logic [NREAD-1:0][XLEN-1:0] rdata;
        logic [NREAD-1:0]           busy;
    } exp_t;

    logic Clock = 1'b0;
    logic nReset = 1'b0;

    always #5 Clock = ~Clock;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

    reg_file_mp #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .ZERO_REG (1)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus)
    );

    // Reference model state
    word_t            m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    word_t            m_rdata [NREAD];
    logic [NREAD-1:0] m_bsy;
    exp_t             exp_q [$];

    int total = 0;
    int bad   = 0;

    function automatic void check_output(input string name, input logic [XLEN-1:0] act,
                                         input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        for (int p = 0; p < NREAD; p++) m_rdata[p] = '0;
        m_busy = '0;
        m_bsy  = '0;
    endfunction

    task automatic drive_idle();
        bus.Wreg  = 1'b0;
        bus.Wrd   = '0;
        bus.Wdata = '0;
        bus.Ren   = '0;
        for (int p = 0; p < NREAD; p++) bus.Raddr[p] = '0;
`ifdef REGFILE_SCOREBOARD_EN
        bus.Issue    = 1'b0;
        bus.Issue_rd = '0;
`endif
    endtask

    // Drive one cycle of stimulus and queue what the ports must show after the edge.
    task automatic apply_stimulus(input logic wreg, input logic [AW-1:0] wrd,
                                  input word_t wdata, input logic [NREAD-1:0] ren,
                                  input logic [NREAD-1:0][AW-1:0] raddr,
                                  input logic issue, input logic [AW-1:0] issue_rd);
        logic [NREGS-1:0] busy_after;
        exp_t e;
        @(negedge Clock);
        bus.Wreg  = wreg;
        bus.Wrd   = wrd;
        bus.Wdata = wdata;
        bus.Ren   = ren;
        for (int p = 0; p < NREAD; p++) bus.Raddr[p] = raddr[p];
`ifdef REGFILE_SCOREBOARD_EN
        bus.Issue    = issue;
        bus.Issue_rd = issue_rd;
`endif
        busy_after = m_busy;
        if (wreg) busy_after[wrd] = 1'b0;
        if (issue && issue_rd != 0) busy_after[issue_rd] = 1'b1;
        for (int p = 0; p < NREAD; p++) begin
            if (ren[p]) begin
                if (raddr[p] == 0)                     m_rdata[p] = '0;
                else if (wreg && wrd == raddr[p])      m_rdata[p] = wdata;
                else                                   m_rdata[p] = m_regs[raddr[p]];
                m_bsy[p] = busy_after[raddr[p]];
            end
            e.rdata[p] = m_rdata[p];
        end
        e.busy = m_bsy;
        exp_q.push_back(e);
        if (wreg && wrd != 0) m_regs[wrd] = wdata;
        m_busy = busy_after;
    endtask

    // Asynchronous reset in the middle of a run; outputs must clear at once.
    task automatic apply_reset();
        @(negedge Clock);
        drive_idle();
        nReset = 1'b0;
        #1;
        for (int p = 0; p < NREAD; p++)
            check_output($sformatf("reset_rdata%0d", p), bus.Rdata[p], '0);
`ifdef REGFILE_SCOREBOARD_EN
        check_output("reset_busy", {{(XLEN-NREAD){1'b0}}, bus.Busy}, '0);
`endif
        model_clear();
        @(negedge Clock);
        nReset = 1'b1;
    endtask

    // Monitor: compare each queued expectation just after the edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int p = 0; p < NREAD; p++)
                    check_output($sformatf("rdata%0d", p), bus.Rdata[p], e.rdata[p]);
`ifdef REGFILE_SCOREBOARD_EN
                check_output("busy", {{(XLEN-NREAD){1'b0}}, bus.Busy},
                             {{(XLEN-NREAD){1'b0}}, e.busy});
`endif
            end
        end
    end

    initial begin
        int guard;
        logic [NREAD-1:0][AW-1:0] ra;
        logic [AW-1:0] rd;
        drive_idle();
        model_clear();
        #1;
        for (int p = 0; p < NREAD; p++)
            check_output($sformatf("init_rdata%0d", p), bus.Rdata[p], '0);
        @(negedge Clock);
        nReset = 1'b1;

        // Every address reads zero after reset
        for (int a = 0; a < NREGS; a += 2)
            apply_stimulus(1'b0, '0, '0, 2'b11, {AW'(a + 1), AW'(a)}, 1'b0, '0);

        // Plain write then read
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, {5'd0, 5'd0}, 1'b0, '0);
        apply_stimulus(1'b0, '0, '0, 2'b01, {5'd0, 5'd5}, 1'b0, '0);

        // Same-cycle bypass on both ports
        apply_stimulus(1'b1, 5'd7, 32'h1234, 2'b11, {5'd7, 5'd7}, 1'b0, '0);

        // Register 0 stays zero, including in the write cycle
        apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 2'b11, {5'd0, 5'd0}, 1'b0, '0);
        apply_stimulus(1'b0, '0, '0, 2'b11, {5'd0, 5'd0}, 1'b0, '0);

        // Hold on port 1 while the addressed register changes
        apply_stimulus(1'b1, 5'd2, 32'hA, 2'b00, {5'd0, 5'd0}, 1'b0, '0);
        apply_stimulus(1'b0, '0, '0, 2'b10, {5'd2, 5'd0}, 1'b0, '0);
        apply_stimulus(1'b1, 5'd3, 32'hB, 2'b00, {5'd3, 5'd0}, 1'b0, '0);
        apply_stimulus(1'b0, '0, '0, 2'b00, {5'd3, 5'd0}, 1'b0, '0);
        apply_stimulus(1'b0, '0, '0, 2'b10, {5'd3, 5'd0}, 1'b0, '0);

        // Scoreboard sequence (busy values only compared when the feature is built)
        apply_stimulus(1'b0, '0, '0, 2'b00, {5'd0, 5'd0}, 1'b1, 5'd9);
        apply_stimulus(1'b0, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b0, '0);
        apply_stimulus(1'b1, 5'd9, 32'h99, 2'b11, {5'd9, 5'd9}, 1'b1, 5'd9);
        apply_stimulus(1'b1, 5'd9, 32'h98, 2'b01, {5'd0, 5'd9}, 1'b0, '0);
        apply_stimulus(1'b0, '0, '0, 2'b00, {5'd0, 5'd0}, 1'b1, 5'd0);
        apply_stimulus(1'b0, '0, '0, 2'b11, {5'd9, 5'd0}, 1'b1, 5'd9);
        apply_stimulus(1'b0, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b0, '0);

        // Reset mid-sequence, then normal operation from the first edge
        apply_reset();
        apply_stimulus(1'b0, '0, '0, 2'b11, {5'd9, 5'd5}, 1'b0, '0);
        apply_stimulus(1'b1, 5'd4, 32'h44, 2'b01, {5'd0, 5'd4}, 1'b0, '0);

        // Randomized traffic, biased toward a few registers to exercise bypass/busy
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NREAD; p++)
                ra[p] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            rd = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            apply_stimulus(1'($urandom), rd, $urandom, NREAD'($urandom), ra,
                           1'($urandom), AW'($urandom_range(0, 3)));
            if (i == 200) apply_reset();
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge Clock);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
